// File: rtl/arth_share_arbiter.sv
// Round-robin arbiter that time-shares one 32-bit add/subtract unit (anArth)
// among NREQ requesters and returns a tagged, registered result.

module anArth (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        r,
  output logic [31:0] z,
  output logic        cout
);
  logic [32:0] sum;

  // Subtract is a + ~b + 1, so cout=1 means no borrow (a >= b unsigned).
  assign sum  = {1'b0, a} + {1'b0, (r ? ~b : b)} + {32'b0, r};
  assign z    = sum[31:0];
  assign cout = sum[32];
endmodule

module arth_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_z,
  output logic                 rsp_cout,
  output logic                 rsp_ovf,
  output logic [1:0]           dbg_state,
  output logic [IDW-1:0]       dbg_ptr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  g_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            sub_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [31:0]     rsp_z_q;
  logic            rsp_cout_q;
  logic            rsp_ovf_q;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    scan_sum;
  logic [IDW-1:0]  scan_idx;

  logic [31:0]     arth_z;
  logic            arth_cout;
  logic            arth_ovf;

  // Rotating priority: first valid requester at or after ptr_q, modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. req_ready is one-hot (granted requester) only in IDLE; the
  // response is offered from RESP and retires on rsp_valid && rsp_ready.
  assign req_ready = (state_q == IDLE && !reset && gnt_found) ?
                     (NREQ'(1) << gnt_idx) : '0;

  anArth u_arth (
    .a    (a_q),
    .b    (b_q),
    .r    (sub_q),
    .z    (arth_z),
    .cout (arth_cout)
  );

  assign arth_ovf = sub_q ? ((a_q[31] != b_q[31]) && (arth_z[31] != a_q[31]))
                          : ((a_q[31] == b_q[31]) && (arth_z[31] != a_q[31]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            a_q     <= req_a[32*gnt_idx +: 32];
            b_q     <= req_b[32*gnt_idx +: 32];
            sub_q   <= req_sub[gnt_idx];
            g_q     <= gnt_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_z_q     <= arth_z;
          rsp_cout_q  <= arth_cout;
          rsp_ovf_q   <= arth_ovf;
          rsp_id_q    <= g_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= (g_q == IDW'(NREQ-1)) ? '0 : g_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_arth_share_arbiter.sv
// Bench for arth_share_arbiter: directed scenarios plus a randomized run
// checked against an arithmetic/round-robin reference model.

module tb_arth_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_sub;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_z;
  logic                rsp_cout;
  logic                rsp_ovf;
  logic [1:0]          dbg_state;
  logic [IDW-1:0]      dbg_ptr;

  int checks = 0;
  int failures = 0;

  logic [IDW+33:0] exp_q[$];
  int              stamp_q[$];

  always #5 clk = ~clk;

  arth_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Reference: result as {cout, ovf, z} from plain wide arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint sv;
    logic [31:0] z;
    logic c;
    logic o;
    if (sub) begin
      z  = a - b;
      c  = (a >= b);
      sv = longint'($signed(a)) - longint'($signed(b));
    end else begin
      z  = a + b;
      c  = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF;
      sv = longint'($signed(a)) + longint'($signed(b));
    end
    o = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {c, o, z};
  endfunction

  function automatic void pick(input logic [NREQ-1:0] v, input int p, output logic f, output int g);
    f = 1'b0;
    g = 0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (!f && v[j]) begin
        f = 1'b1;
        g = j;
      end
    end
  endfunction

  task automatic present(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_sub[id]        = sub;
    req_valid[id]      = 1'b1;
  endtask

  // Drives one request on an idle arbiter (rsp_ready assumed 1) and reports what was seen.
  task automatic drive_txn(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                           output logic [NREQ-1:0] rdy_seen, output int lat,
                           output logic [IDW-1:0] id_o, output logic [31:0] z_o,
                           output logic c_o, output logic o_o, output logic tmo);
    int n;
    tmo = 1'b0;
    present(id, a, b, sub);
    n = 0;
    do begin
      @(negedge clk);
      rdy_seen = req_ready;
      n++;
    end while (!req_ready[id] && n < 10);
    if (!req_ready[id]) tmo = 1'b1;
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    if (!rsp_valid) tmo = 1'b1;
    lat  = n;
    id_o = rsp_id;
    z_o  = rsp_z;
    c_o  = rsp_cout;
    o_o  = rsp_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    @(posedge clk);
    #1;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end checks++;
    if ({rsp_id, rsp_z, rsp_cout, rsp_ovf} !== '0) begin failures++; $display("FAIL reset_rsp_fields got id=%0d z=%h c=%b o=%b exp all 0", rsp_id, rsp_z, rsp_cout, rsp_ovf); end checks++;
    if (dbg_state !== 2'd0 || dbg_ptr !== '0) begin failures++; $display("FAIL reset_state got state=%0d ptr=%0d exp 0/0", dbg_state, dbg_ptr); end checks++;
    req_valid = '0;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [31:0] z; logic c, o, tmo;
    rsp_ready = 1'b1;
    drive_txn(0, 32'd5, 32'd7, 1'b0, rdy, lat, id, z, c, o, tmo);
    if (tmo) begin failures++; $display("FAIL add_timeout got=timeout exp=response"); end checks++;
    if (rdy !== 4'b0001) begin failures++; $display("FAIL add_ready got=%b exp=0001", rdy); end checks++;
    if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end checks++;
    if ({id, z, c, o} !== {2'd0, 32'd12, 1'b0, 1'b0}) begin failures++; $display("FAIL add_basic got id=%0d z=%h c=%b o=%b exp id=0 z=c c=0 o=0", id, z, c, o); end checks++;
    rsp_ready = 1'b1;
    drive_txn(1, 32'h7FFF_FFFF, 32'd1, 1'b0, rdy, lat, id, z, c, o, tmo);
    if (tmo || {id, z, c, o} !== {2'd1, 32'h8000_0000, 1'b0, 1'b1}) begin failures++; $display("FAIL add_ovf got tmo=%b id=%0d z=%h c=%b o=%b exp id=1 z=80000000 c=0 o=1", tmo, id, z, c, o); end checks++;
    drive_txn(1, 32'hFFFF_FFFF, 32'd1, 1'b0, rdy, lat, id, z, c, o, tmo);
    if (tmo || {id, z, c, o} !== {2'd1, 32'h0, 1'b1, 1'b0}) begin failures++; $display("FAIL add_carry got tmo=%b id=%0d z=%h c=%b o=%b exp id=1 z=0 c=1 o=0", tmo, id, z, c, o); end checks++;
  endtask

  task automatic test_sub();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [31:0] z; logic c, o, tmo;
    rsp_ready = 1'b1;
    drive_txn(2, 32'd3, 32'd5, 1'b1, rdy, lat, id, z, c, o, tmo);
    if (tmo || rdy !== 4'b0100 || {id, z, c, o} !== {2'd2, 32'hFFFF_FFFE, 1'b0, 1'b0}) begin failures++; $display("FAIL sub_neg got tmo=%b rdy=%b id=%0d z=%h c=%b o=%b exp rdy=0100 id=2 z=fffffffe c=0 o=0", tmo, rdy, id, z, c, o); end checks++;
    drive_txn(2, 32'd5, 32'd3, 1'b1, rdy, lat, id, z, c, o, tmo);
    if (tmo || {id, z, c, o} !== {2'd2, 32'd2, 1'b1, 1'b0}) begin failures++; $display("FAIL sub_pos got tmo=%b id=%0d z=%h c=%b o=%b exp id=2 z=2 c=1 o=0", tmo, id, z, c, o); end checks++;
    drive_txn(2, 32'h8000_0000, 32'd1, 1'b1, rdy, lat, id, z, c, o, tmo);
    if (tmo || {id, z, c, o} !== {2'd2, 32'h7FFF_FFFF, 1'b1, 1'b1}) begin failures++; $display("FAIL sub_ovf got tmo=%b id=%0d z=%h c=%b o=%b exp id=2 z=7fffffff c=1 o=1", tmo, id, z, c, o); end checks++;
  endtask

  task automatic test_round_robin();
    int mptr = 0; int nrsp = 0; int last = 0; logic f; int g;
    logic [33:0] r;
    reset = 1'b1;
    #1 reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) present(i, 32'(i*1000 + 7), 32'(i*3 + 1), i[0]);
    for (int cyc = 0; cyc < 30 && nrsp < 6; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        pick(4'b1111, mptr, f, g);
        r = model(32'(g*1000 + 7), 32'(g*3 + 1), g[0]);
        if (rsp_id !== IDW'(g) || {rsp_cout, rsp_ovf, rsp_z} !== r) begin failures++; $display("FAIL rr_grant n=%0d got id=%0d z=%h exp id=%0d z=%h", nrsp, rsp_id, rsp_z, g, r[31:0]); end checks++;
        if (nrsp > 0) begin
          if (cyc - last !== 3) begin failures++; $display("FAIL rr_interval n=%0d got=%0d exp=3", nrsp, cyc - last); end checks++;
        end
        last = cyc;
        mptr = (g + 1) % NREQ;
        nrsp++;
      end
    end
    if (nrsp !== 6) begin failures++; $display("FAIL rr_count got=%0d exp=6", nrsp); end checks++;
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int n = 0;
    rsp_ready = 1'b0;
    present(3, 32'h1000_0000, 32'h0000_0234, 1'b0);
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    if (!rsp_valid) begin failures++; $display("FAIL bp_timeout got=no response exp=response"); end checks++;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_z !== 32'h1000_0234 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0) begin
        failures++; $display("FAIL bp_hold k=%0d got v=%b id=%0d z=%h exp v=1 id=3 z=10000234", k, rsp_valid, rsp_id, rsp_z);
      end checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready k=%0d got=%b exp=0000", k, req_ready); end checks++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin failures++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1000", rsp_valid, req_ready); end checks++;
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    logic [NREQ-1:0] rdy; int lat; logic [IDW-1:0] id; logic [31:0] z; logic c, o, tmo;
    int n = 0;
    rsp_ready = 1'b1;
    drive_txn(2, 32'd9, 32'd4, 1'b1, rdy, lat, id, z, c, o, tmo);
    if (tmo || {id, z, c, o} !== {2'd2, 32'd5, 1'b1, 1'b0}) begin failures++; $display("FAIL ar_pre got tmo=%b id=%0d z=%h exp id=2 z=5", tmo, id, z); end checks++;
    present(0, 32'h1234, 32'd1, 1'b0);
    @(posedge clk);
    #3;
    present(1, 32'h40, 32'h2, 1'b0);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    #1;
    if (rsp_valid !== 1'b0 || {rsp_id, rsp_z, rsp_cout, rsp_ovf} !== '0) begin failures++; $display("FAIL ar_outputs got v=%b id=%0d z=%h c=%b o=%b exp all 0", rsp_valid, rsp_id, rsp_z, rsp_cout, rsp_ovf); end checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL ar_ready got=%b exp=0000", req_ready); end checks++;
    if (dbg_state !== 2'd0 || dbg_ptr !== '0) begin failures++; $display("FAIL ar_state got state=%0d ptr=%0d exp 0/0", dbg_state, dbg_ptr); end checks++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL ar_regrant got=%b exp=0010", req_ready); end checks++;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_z !== 32'h42) begin failures++; $display("FAIL ar_after got v=%b id=%0d z=%h exp v=1 id=1 z=42", rsp_valid, rsp_id, rsp_z); end checks++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] vld = '0;
    logic [31:0] ma[NREQ];
    logic [31:0] mb[NREQ];
    logic        ms[NREQ];
    logic [31:0] specials[5];
    int mptr = 0; int acc; logic f; int g; logic exp_rv;
    logic [NREQ-1:0] exp_ready;
    logic [IDW+33:0] e;
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000; specials[4] = 32'hFFFF_FFFF;
    exp_q.delete();
    stamp_q.delete();
    req_valid = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      acc = -1;
      exp_ready = '0;
      f = 1'b0;
      g = 0;
      if (exp_q.size() == 0) pick(vld, mptr, f, g);
      if (f) exp_ready[g] = 1'b1;
      if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end checks++;
      exp_rv = (exp_q.size() != 0) && (cyc - stamp_q[0] >= 2);
      if (rsp_valid !== exp_rv) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, exp_rv); end checks++;
      if (exp_rv && rsp_ready) begin
        e = exp_q.pop_front();
        void'(stamp_q.pop_front());
        if ({rsp_id, rsp_cout, rsp_ovf, rsp_z} !== e) begin
          failures++; $display("FAIL rnd_result cyc=%0d got id=%0d c=%b o=%b z=%h exp id=%0d c=%b o=%b z=%h", cyc, rsp_id, rsp_cout, rsp_ovf, rsp_z, e[IDW+33:34], e[33], e[32], e[31:0]);
        end checks++;
        mptr = (int'(e[IDW+33:34]) + 1) % NREQ;
      end
      if (f) begin
        exp_q.push_back({IDW'(g), model(ma[g], mb[g], ms[g])});
        stamp_q.push_back(cyc);
        acc = g;
      end
      @(posedge clk);
      #1;
      if (acc >= 0) vld[acc] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && $urandom_range(0, 3) == 0) begin
          ma[i] = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
          mb[i] = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
          ms[i] = 1'($urandom_range(0, 1));
          vld[i] = 1'b1;
          present(i, ma[i], mb[i], ms[i]);
        end
      end
      req_valid = vld;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
